// File: rtl/parity_stream_gen_check.sv
// -----------------------------------------------------------------------------
// parity_stream_gen_check
//
// Registered parity generator and checker for a word stream.
//
// Generator path: words arrive on a valid/ready handshake (tx_*), are stored
// in a single output register together with their parity bit, and are offered
// downstream on gen_* with a one-cycle latency. The stage is a one-deep skid-
// free pipeline register: it sustains one word per cycle while gen_ready is
// high and holds its contents stable while the downstream stalls.
//
// Checker path: received word+parity pairs (rx_*, no backpressure) have their
// parity recomputed. One cycle later chk_valid/chk_error report the result.
// Mismatches bump a saturating error counter and set a sticky flag; both are
// cleared by clr_err, except that an error arriving in the same cycle as
// clr_err is kept.
//
// Parity: mode=0 even (p = ^data), mode=1 odd (p = ~^data). The mode input is
// shared by both paths and sampled in the cycle a word is accepted/received.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   mode         0 = even parity, 1 = odd parity
//   tx_valid     source word valid
//   tx_data      source word [DATA_W]
//   tx_ready     generator can accept a word this cycle
//   gen_valid    gen_data/gen_parity valid
//   gen_data     registered copy of the accepted word [DATA_W]
//   gen_parity   parity bit for gen_data
//   gen_ready    downstream accepts the gen word this cycle
//   rx_valid     received word+parity valid
//   rx_data      received word [DATA_W]
//   rx_parity    received parity bit
//   chk_valid    check result valid (one cycle after rx_valid)
//   chk_error    parity mismatch for that word, 0 when chk_valid=0
//   err_count    saturating mismatch count [CNT_W]
//   err_sticky   set on any mismatch, held until clr_err
//   clr_err      synchronous clear of err_count and err_sticky
// -----------------------------------------------------------------------------
module parity_stream_gen_check #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,

    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,

    output logic              gen_valid,
    output logic [DATA_W-1:0] gen_data,
    output logic              gen_parity,
    input  logic              gen_ready,

    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_parity,

    output logic              chk_valid,
    output logic              chk_error,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_sticky,
    input  logic              clr_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Parity trees. Prefix-XOR chains over each input word; the last tap is the
    // even parity of the whole word, and XOR with mode turns it into odd parity.
    // -------------------------------------------------------------------------
    logic [DATA_W:0] tx_xor_chain;
    logic [DATA_W:0] rx_xor_chain;

    assign tx_xor_chain[0] = 1'b0;
    assign rx_xor_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_parity_tree
            assign tx_xor_chain[gi+1] = tx_xor_chain[gi] ^ tx_data[gi];
            assign rx_xor_chain[gi+1] = rx_xor_chain[gi] ^ rx_data[gi];
        end
    endgenerate

    logic tx_parity_calc;
    logic rx_parity_calc;

    assign tx_parity_calc = tx_xor_chain[DATA_W] ^ mode;
    assign rx_parity_calc = rx_xor_chain[DATA_W] ^ mode;

    // -------------------------------------------------------------------------
    // Generator stage
    // -------------------------------------------------------------------------
    logic              gen_valid_reg;
    logic [DATA_W-1:0] gen_data_reg;
    logic              gen_parity_reg;
    logic              tx_accept;

    // The register can take a new word when it is empty or being drained this
    // cycle. Gated with rst so the source never sees a handshake while the
    // block is held in reset.
    assign tx_ready  = !rst && (!gen_valid_reg || gen_ready);
    assign tx_accept = tx_valid && tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_valid_reg  <= 1'b0;
            gen_data_reg   <= '0;
            gen_parity_reg <= 1'b0;
        end else begin
            if (tx_accept) begin
                // Parity is frozen at accept time, so a later mode change
                // never alters a word already sitting in the register.
                gen_valid_reg  <= 1'b1;
                gen_data_reg   <= tx_data;
                gen_parity_reg <= tx_parity_calc;
            end else if (gen_ready) begin
                // Drained with nothing behind it. Data is left as-is; only the
                // valid flag matters once the word has been consumed.
                gen_valid_reg  <= 1'b0;
            end
        end
    end

    assign gen_valid  = gen_valid_reg;
    assign gen_data   = gen_data_reg;
    assign gen_parity = gen_parity_reg;

    // -------------------------------------------------------------------------
    // Checker
    // -------------------------------------------------------------------------
    logic             rx_mismatch;
    logic             err_event;
    logic             chk_valid_reg;
    logic             chk_error_reg;
    logic [CNT_W-1:0] err_count_reg;
    logic [CNT_W-1:0] err_count_next;
    logic             err_sticky_reg;
    logic             err_sticky_next;

    assign rx_mismatch = (rx_parity != rx_parity_calc);
    assign err_event   = rx_valid && rx_mismatch;

    // Counter/sticky update. clr_err wins over history but not over an error
    // seen in the same cycle: that error restarts the count at one.
    always_comb begin
        err_count_next  = err_count_reg;
        err_sticky_next = err_sticky_reg;
        if (clr_err) begin
            err_count_next  = err_event ? CNT_ONE : '0;
            err_sticky_next = err_event;
        end else if (err_event) begin
            err_sticky_next = 1'b1;
            if (err_count_reg != CNT_MAX) begin
                err_count_next = err_count_reg + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_valid_reg  <= 1'b0;
            chk_error_reg  <= 1'b0;
            err_count_reg  <= '0;
            err_sticky_reg <= 1'b0;
        end else begin
            chk_valid_reg  <= rx_valid;
            chk_error_reg  <= err_event;
            err_count_reg  <= err_count_next;
            err_sticky_reg <= err_sticky_next;
        end
    end

    assign chk_valid  = chk_valid_reg;
    assign chk_error  = chk_error_reg;
    assign err_count  = err_count_reg;
    assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_parity_stream_gen_check.sv
// -----------------------------------------------------------------------------
// Testbench for parity_stream_gen_check. Two instances share all inputs:
// dut_a uses the default widths, dut_b uses CNT_W=2 to reach saturation.
// Expected values come from a behavioural model: parity from a ones count,
// the generator register as a queue of at most one word, and the error
// counters as plain saturating integers.
// -----------------------------------------------------------------------------
module tb_parity_stream_gen_check;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       gen_ready = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_parity = 1'b0;
    logic       clr_err = 1'b0;

    logic       tx_ready, gen_valid, gen_parity, chk_valid, chk_error, err_sticky;
    logic [7:0] gen_data, err_count;
    logic       tx_ready_b, gen_valid_b, gen_parity_b, chk_valid_b, chk_error_b, err_sticky_b;
    logic [7:0] gen_data_b;
    logic [1:0] err_count_b;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [8:0] exp_q[$];        // {parity, data} held in the generator register
    bit         exp_chk_valid;
    bit         exp_chk_error;
    int         exp_cnt_a;       // saturates at 255
    int         exp_cnt_b;       // saturates at 3
    bit         exp_sticky;

    always #5 clk = ~clk;

    parity_stream_gen_check #(.DATA_W(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .mode(mode),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .gen_valid(gen_valid), .gen_data(gen_data), .gen_parity(gen_parity),
        .gen_ready(gen_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_parity(rx_parity),
        .chk_valid(chk_valid), .chk_error(chk_error),
        .err_count(err_count), .err_sticky(err_sticky), .clr_err(clr_err)
    );

    parity_stream_gen_check #(.DATA_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .mode(mode),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready_b),
        .gen_valid(gen_valid_b), .gen_data(gen_data_b), .gen_parity(gen_parity_b),
        .gen_ready(gen_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_parity(rx_parity),
        .chk_valid(chk_valid_b), .chk_error(chk_error_b),
        .err_count(err_count_b), .err_sticky(err_sticky_b), .clr_err(clr_err)
    );

    // Parity bit that makes the total ones count even (m=0) or odd (m=1).
    function automatic bit ref_par(input logic [7:0] d, input logic m);
        return bit'(($countones(d) % 2) == 1) ^ m;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        exp_chk_valid = 0;
        exp_chk_error = 0;
        exp_cnt_a     = 0;
        exp_cnt_b     = 0;
        exp_sticky    = 0;
    endfunction

    // Advance the model across one rising edge using the current inputs, then
    // move to 1 time unit after that edge.
    task automatic tick();
        bit pop, push, ev;
        pop  = (exp_q.size() != 0) && gen_ready;
        push = tx_valid && ((exp_q.size() == 0) || gen_ready);
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back({ref_par(tx_data, mode), tx_data});
        ev = rx_valid && (rx_parity != ref_par(rx_data, mode));
        exp_chk_valid = rx_valid;
        exp_chk_error = ev;
        if (clr_err) begin
            exp_cnt_a  = ev ? 1 : 0;
            exp_cnt_b  = ev ? 1 : 0;
            exp_sticky = ev;
        end else if (ev) begin
            exp_sticky = 1;
            if (exp_cnt_a < 255) exp_cnt_a++;
            if (exp_cnt_b < 3)   exp_cnt_b++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tx_valid = 0; rx_valid = 0; clr_err = 0; gen_ready = 1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        model_reset();
        #2;
        total++;
        if ({gen_valid, gen_data, gen_parity, chk_valid, chk_error, err_count, err_sticky, tx_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got gv=%0b gd=%h gp=%0b cv=%0b ce=%0b cnt=%0d st=%0b rdy=%0b, need all 0",
                     gen_valid, gen_data, gen_parity, chk_valid, chk_error, err_count, err_sticky, tx_ready);
        end
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();
        #1;
        total++;
        if (tx_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %0b need 1", tx_ready);
        end
        $display("test_reset: done");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_even_back_to_back();
        logic [7:0] words[3] = '{8'b01010101, 8'b11111110, 8'b00110001};
        logic       pars[3]  = '{1'b0, 1'b1, 1'b1};
        idle_inputs();
        mode = 0;
        for (int i = 0; i < 3; i++) begin
            tx_valid = 1; tx_data = words[i];
            #1;
            total++;
            if (tx_ready !== 1'b1) begin
                bad++; $display("FAIL even_b2b_ready[%0d]: got %0b need 1", i, tx_ready);
            end
            tick();
            total++;
            if (gen_valid !== 1'b1 || gen_data !== words[i] || gen_parity !== pars[i]) begin
                bad++;
                $display("FAIL even_b2b_word[%0d]: got v=%0b d=%h p=%0b need v=1 d=%h p=%0b",
                         i, gen_valid, gen_data, gen_parity, words[i], pars[i]);
            end
            $display("even tx %b -> parity %0b", words[i], gen_parity);
        end
        tx_valid = 0;
        tick();
        total++;
        if (gen_valid !== 1'b0) begin
            bad++; $display("FAIL even_b2b_drain: gen_valid got %0b need 0", gen_valid);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_odd_loopback();
        idle_inputs();
        mode = 1;
        tx_valid = 1; tx_data = 8'b01010101;
        tick();
        total++;
        if (gen_parity !== 1'b1) begin
            bad++; $display("FAIL odd_par0: got %0b need 1", gen_parity);
        end
        // Feed the generator output back into the checker while the second word loads.
        rx_valid = gen_valid; rx_data = gen_data; rx_parity = gen_parity;
        tx_data = 8'b11001100;
        tick();
        total++;
        if (gen_parity !== 1'b1 || gen_data !== 8'b11001100) begin
            bad++; $display("FAIL odd_par1: got d=%h p=%0b need d=cc p=1", gen_data, gen_parity);
        end
        tx_valid = 0;
        rx_valid = gen_valid; rx_data = gen_data; rx_parity = gen_parity;
        tick();
        rx_valid = 0;
        total++;
        if (chk_valid !== 1'b1 || chk_error !== 1'b0 || err_count !== 8'd0) begin
            bad++; $display("FAIL odd_loop_check: got cv=%0b ce=%0b cnt=%0d need 1 0 0", chk_valid, chk_error, err_count);
        end
        $display("odd loopback: chk_error=%0b err_count=%0d", chk_error, err_count);
        tick();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        idle_inputs();
        mode = 0;
        tx_valid = 1; tx_data = 8'hA1;
        tick();
        gen_ready = 0; tx_data = 8'hB2;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (tx_ready !== 1'b0) begin
                bad++; $display("FAIL bp_ready[%0d]: got %0b need 0", i, tx_ready);
            end
            tick();
            total++;
            if (gen_valid !== 1'b1 || gen_data !== 8'hA1 || gen_parity !== ref_par(8'hA1, 1'b0)) begin
                bad++; $display("FAIL bp_hold[%0d]: got v=%0b d=%h need v=1 d=a1", i, gen_valid, gen_data);
            end
        end
        gen_ready = 1;
        #1;
        total++;
        if (tx_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release_ready: got %0b need 1", tx_ready);
        end
        tick();
        total++;
        if (gen_valid !== 1'b1 || gen_data !== 8'hB2) begin
            bad++; $display("FAIL bp_next_word: got v=%0b d=%h need v=1 d=b2", gen_valid, gen_data);
        end
        tx_valid = 0;
        tick();
        total++;
        if (gen_valid !== 1'b0) begin
            bad++; $display("FAIL bp_no_dup: gen_valid got %0b need 0", gen_valid);
        end
        $display("backpressure: held a1 for 3 cycles, then b2 once");
    endtask

    // -------------------------------------------------------------------------
    task automatic test_check_error();
        idle_inputs();
        mode = 0;
        clr_err = 1;
        tick();
        clr_err = 0;
        rx_valid = 1; rx_data = 8'b00110101; rx_parity = 1;
        tick();
        total++;
        if (chk_valid !== 1 || chk_error !== 1 || err_count !== 8'd1 || err_sticky !== 1) begin
            bad++; $display("FAIL chk_bad: got cv=%0b ce=%0b cnt=%0d st=%0b need 1 1 1 1",
                            chk_valid, chk_error, err_count, err_sticky);
        end
        rx_parity = 0;
        tick();
        total++;
        if (chk_valid !== 1 || chk_error !== 0 || err_count !== 8'd1 || err_sticky !== 1) begin
            bad++; $display("FAIL chk_good: got cv=%0b ce=%0b cnt=%0d st=%0b need 1 0 1 1",
                            chk_valid, chk_error, err_count, err_sticky);
        end
        rx_valid = 0;
        tick();
        total++;
        if (chk_valid !== 0 || chk_error !== 0) begin
            bad++; $display("FAIL chk_idle: got cv=%0b ce=%0b need 0 0", chk_valid, chk_error);
        end
        $display("check error: sticky=%0b count=%0d", err_sticky, err_count);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_saturate();
        int need_b[5] = '{1, 2, 3, 3, 3};
        idle_inputs();
        clr_err = 1;
        tick();
        clr_err = 0;
        rx_valid = 1;
        for (int i = 0; i < 5; i++) begin
            mode = 1'($urandom_range(0, 1));
            rx_data = 8'($urandom);
            rx_parity = ~ref_par(rx_data, mode);
            tick();
            total++;
            if (err_count_b !== 2'(need_b[i]) || err_count !== 8'(i + 1)) begin
                bad++; $display("FAIL sat[%0d]: got b=%0d a=%0d need b=%0d a=%0d",
                                i, err_count_b, err_count, need_b[i], i + 1);
            end
            $display("saturate bad word %0d: cnt2=%0d cnt8=%0d", i, err_count_b, err_count);
        end
        clr_err = 1;
        rx_data = 8'($urandom); rx_parity = ~ref_par(rx_data, mode);
        tick();
        total++;
        if (err_count_b !== 2'd1 || err_count !== 8'd1 || err_sticky_b !== 1) begin
            bad++; $display("FAIL clr_with_err: got b=%0d a=%0d st=%0b need 1 1 1", err_count_b, err_count, err_sticky_b);
        end
        rx_valid = 0;
        tick();
        total++;
        if (err_count_b !== 2'd0 || err_sticky_b !== 0 || err_count !== 8'd0 || err_sticky !== 0) begin
            bad++; $display("FAIL clr_alone: got b=%0d stb=%0b a=%0d sta=%0b need 0", err_count_b, err_sticky_b, err_count, err_sticky);
        end
        clr_err = 0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_random();
        int n_bad = 0;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            tx_valid  = ($urandom_range(0, 3) != 0);
            tx_data   = 8'($urandom);
            gen_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            rx_valid  = $urandom_range(0, 1);
            rx_data   = 8'($urandom);
            rx_parity = ref_par(rx_data, mode) ^ ($urandom_range(0, 4) == 0);
            clr_err   = ($urandom_range(0, 40) == 0);
            #1;
            total++;
            if (tx_ready !== ((exp_q.size() == 0) || gen_ready)) begin
                bad++; n_bad++; $display("FAIL rnd_ready c=%0d: got %0b", c, tx_ready);
            end
            tick();
            total++;
            if (gen_valid !== (exp_q.size() != 0) ||
                (exp_q.size() != 0 && {gen_parity, gen_data} !== exp_q[0])) begin
                bad++; n_bad++;
                $display("FAIL rnd_gen c=%0d: got v=%0b p=%0b d=%h need v=%0b pd=%h",
                         c, gen_valid, gen_parity, gen_data, exp_q.size() != 0,
                         (exp_q.size() != 0) ? exp_q[0] : 9'h0);
            end
            total++;
            if (chk_valid !== exp_chk_valid || chk_error !== exp_chk_error ||
                err_count !== 8'(exp_cnt_a) || err_count_b !== 2'(exp_cnt_b) ||
                err_sticky !== exp_sticky || err_sticky_b !== exp_sticky) begin
                bad++; n_bad++;
                $display("FAIL rnd_chk c=%0d: got cv=%0b ce=%0b a=%0d b=%0d st=%0b need %0b %0b %0d %0d %0b",
                         c, chk_valid, chk_error, err_count, err_count_b, err_sticky,
                         exp_chk_valid, exp_chk_error, exp_cnt_a, exp_cnt_b, exp_sticky);
            end
        end
        idle_inputs();
        $display("random: 400 cycles, err_count=%0d, mismatched cycles=%0d", err_count, n_bad);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_midstream();
        logic [7:0] w;
        idle_inputs();
        gen_ready = 0;
        tx_valid = 1; tx_data = 8'h5A;
        rx_valid = 1; rx_data = 8'h0F; rx_parity = 1;
        tick();
        total++;
        if (gen_valid !== 1 || chk_valid !== 1) begin
            bad++; $display("FAIL rst_mid_setup: got gv=%0b cv=%0b need 1 1", gen_valid, chk_valid);
        end
        tx_valid = 0; rx_valid = 0;
        #2;
        rst = 1;
        model_reset();
        #1;
        total++;
        if ({gen_valid, gen_data, gen_parity, chk_valid, chk_error, err_count, err_sticky, tx_ready,
             gen_valid_b, chk_valid_b, err_count_b, err_sticky_b} !== '0) begin
            bad++;
            $display("FAIL rst_mid_async: got gv=%0b gd=%h gp=%0b cv=%0b ce=%0b cnt=%0d st=%0b rdy=%0b",
                     gen_valid, gen_data, gen_parity, chk_valid, chk_error, err_count, err_sticky, tx_ready);
        end
        @(posedge clk); #1;
        rst = 0;
        gen_ready = 1;
        mode = 1;
        w = 8'($urandom);
        tx_valid = 1; tx_data = w;
        #1;
        total++;
        if (tx_ready !== 1) begin
            bad++; $display("FAIL rst_mid_ready: got %0b need 1", tx_ready);
        end
        tick();
        total++;
        if (gen_valid !== 1 || gen_data !== w || gen_parity !== ref_par(w, 1'b1)) begin
            bad++; $display("FAIL rst_mid_first: got v=%0b d=%h p=%0b need v=1 d=%h p=%0b",
                            gen_valid, gen_data, gen_parity, w, ref_par(w, 1'b1));
        end
        $display("reset midstream: first word %h parity %0b", gen_data, gen_parity);
        tx_valid = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_even_back_to_back();
        test_odd_loopback();
        test_backpressure();
        test_check_error();
        test_saturate();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
